cook_time_entry: RTL and testbench
==================================

# cook_time_entry

Cook-time entry block for the egg timer: turns the seconds, minutes and clear buttons into the four BCD programmed digits that the countdown counters load as their start value. Accepts single presses and press-and-hold auto-repeat, with BCD carry and saturation at 99:59. Entry is frozen while the timer runs. Sits between the debounced button synchronizers and the time counter's programming inputs.

## Interface
- `REPEAT_DELAY`, default 500: ticks a button must be held after the initial step before auto-repeat starts (legal range ≥ 1).
- `REPEAT_RATE`, default 100: ticks between auto-repeat steps (legal range ≥ 1).
- `clk` input 1: system clock; the only clock.
- `reset` input 1: asynchronous, active-low reset.
- `tick` input 1: one-cycle timebase pulse, 1 kHz nominal.
- `lock` input 1: high while the timer is counting; freezes entry.
- `btn_sec` input 1: debounced, synchronized level; add one second.
- `btn_min` input 1: debounced, synchronized level; add one minute.
- `btn_clear` input 1: debounced, synchronized level; set 00:00.
- `seconds_prog` output 4: BCD, 0–9.
- `tens_seconds_prog` output 4: BCD, 0–5.
- `minutes_prog` output 4: BCD, 0–9.
- `tens_minutes_prog` output 4: BCD, 0–9.
- `prog_nonzero` output 1: high when the programmed time is not 00:00.
- `changed` output 1: one-cycle pulse on any change to the digits.

## Operation
- Reset (`reset` low, asynchronous): all digits go to 0, `prog_nonzero` = 0, `changed` = 0, FSM goes to IDLE, tick counter = 0, button history registers = 0.
  - A button that is high when reset is released counts as a press.
- Edge detection: press = button high and its history register low.
- Step arithmetic:
  - Second step: add 1 to seconds; 9→0 carries into tens_seconds. Tens_seconds 5→0 carries into minutes. Minutes 9→0 carries into tens_minutes.
  - Minute step: add 1 to minutes, carrying into tens_minutes. Seconds digits are unchanged.
- Saturation (a saturated step changes nothing and does not pulse `changed`):
  - Second step at 99:59 has no effect.
  - Minute step when the minutes are 99 has no effect; the seconds digits are kept.
- FSM states: IDLE, DELAY, REPEAT; it also latches the active button `act` (SEC or MIN).
  - IDLE → DELAY on a `btn_min` or `btn_sec` press. `btn_min` wins if both press in the same cycle. Perform one step of `act`, clear the tick counter.
  - DELAY: count `tick` pulses. On the tick that makes the count equal to `REPEAT_DELAY`: perform a step, clear the counter, go to REPEAT.
  - REPEAT: on the tick that makes the count equal to `REPEAT_RATE`: perform a step, clear the counter.
  - DELAY or REPEAT → IDLE when the `act` button is low. This takes priority over a step in the same cycle.
  - The other button's presses are ignored outside IDLE. They are not queued, and the button must be pressed again once the FSM is in IDLE.
- Clear: a `btn_clear` press sets 00:00 and forces IDLE.
  - Clear has priority over any step in the same cycle.
  - `changed` pulses only if the value was not already 00:00.
- Lock: while `lock` = 1, all buttons are ignored, the FSM is held in IDLE and the tick counter is held at 0.
  - Button history registers keep tracking while locked, so a button held across `lock` falling does not step.
- Tick counter: 10 bits for the defaults; size it to cover the larger of the two parameters.

## Timing
- All state updates on the rising edge of `clk`.
- Latency of 1 clock from a press to the digits:
  - Button rises before edge N.
  - The step is committed at edge N.
  - New digits and `changed` = 1 are visible after edge N, for exactly one cycle.
- Step on a tick: the digits update at the same edge that samples the qualifying `tick`.
- `prog_nonzero` is registered and consistent with the digits in the same cycle.
- Holding a button (T = press edge, tick period P):
  - First step at T.
  - Second step REPEAT_DELAY·P later, ±1 tick of phase.
  - Then one step every REPEAT_RATE·P.
- `changed` never stays high for two consecutive cycles from one step. Back-to-back steps are possible only if the ticks themselves are back to back.

## Test plan
- Carry chain: from reset, press `btn_sec` 60 times with single presses → 01:00. Check `changed` pulses 60 times and `prog_nonzero` rises after the first press.
- Saturation: load 99:58, then three second steps → 99:59 with no further change and `changed` pulsing once only. Load 99:30, minute step → stays 99:30 with no `changed`.
- Auto-repeat: REPEAT_DELAY=5, REPEAT_RATE=2, tick every cycle. Hold `btn_min` for 12 cycles → steps at cycles 0, 5, 7, 9, 11; final value 05:00. Release → IDLE, no further steps.
- Priority: `btn_sec` and `btn_min` rise together → only a minute step (00:00 → 01:00). `btn_clear` and a step in the same cycle → 00:00.
- Lock: with `lock`=1, toggle all buttons → digits unchanged, no `changed`. Drop `lock` with `btn_sec` still held → no step.
- Async reset: assert `reset` low mid-REPEAT, between clock edges → digits go to 0 immediately. After release with buttons low, the FSM is IDLE and there are no steps.

Source files
------------

// File: rtl/cook_time_entry.sv
// Cook-time entry: converts sec/min/clear buttons into four BCD programmed digits,
// with single-press steps, hold-to-repeat, BCD carry and saturation at 99:59.
module cook_time_entry #(
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       lock,
  input  logic       btn_sec,
  input  logic       btn_min,
  input  logic       btn_clear,
  output logic [3:0] seconds_prog,
  output logic [3:0] tens_seconds_prog,
  output logic [3:0] minutes_prog,
  output logic [3:0] tens_minutes_prog,
  output logic       prog_nonzero,
  output logic       changed
);

  localparam int MAX_P = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W = $clog2(MAX_P) + 1;
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
  typedef enum logic {ACT_SEC, ACT_MIN} act_t;

  state_t           state_q, state_d;
  act_t             act_q, act_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]       sec_q, sec_d, tsec_q, tsec_d, min_q, min_d, tmin_q, tmin_d;
  logic             nonzero_q, nonzero_d;
  logic             changed_q, changed_d;
  logic             sec_hist_q, min_hist_q, clr_hist_q;

  logic             press_sec, press_min, press_clr, act_btn;
  logic             do_step;
  act_t             step_act;
  logic             sec_sat, min_sat;
  logic [3:0]       s_sec, s_tsec, s_min, s_tmin;
  logic [3:0]       m_min, m_tmin;

  assign press_sec = btn_sec & ~sec_hist_q;
  assign press_min = btn_min & ~min_hist_q;
  assign press_clr = btn_clear & ~clr_hist_q;
  assign act_btn   = (act_q == ACT_MIN) ? btn_min : btn_sec;
  assign cnt_inc   = cnt_q + CNT_W'(1);

  // Candidate results of a second step and a minute step, with BCD carries.
  always_comb begin
    sec_sat = (tmin_q == 4'd9) && (min_q == 4'd9) && (tsec_q == 4'd5) && (sec_q == 4'd9);
    min_sat = (tmin_q == 4'd9) && (min_q == 4'd9);
    s_sec   = sec_q;
    s_tsec  = tsec_q;
    s_min   = min_q;
    s_tmin  = tmin_q;
    if (sec_q == 4'd9) begin
      s_sec = 4'd0;
      if (tsec_q == 4'd5) begin
        s_tsec = 4'd0;
        if (min_q == 4'd9) begin
          s_min  = 4'd0;
          s_tmin = tmin_q + 4'd1;
        end else begin
          s_min = min_q + 4'd1;
        end
      end else begin
        s_tsec = tsec_q + 4'd1;
      end
    end else begin
      s_sec = sec_q + 4'd1;
    end
    m_min  = min_q;
    m_tmin = tmin_q;
    if (min_q == 4'd9) begin
      m_min  = 4'd0;
      m_tmin = tmin_q + 4'd1;
    end else begin
      m_min = min_q + 4'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    act_d     = act_q;
    cnt_d     = cnt_q;
    sec_d     = sec_q;
    tsec_d    = tsec_q;
    min_d     = min_q;
    tmin_d    = tmin_q;
    changed_d = 1'b0;
    do_step   = 1'b0;
    step_act  = act_q;

    if (lock) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (press_clr) begin
      state_d   = IDLE;
      cnt_d     = '0;
      sec_d     = 4'd0;
      tsec_d    = 4'd0;
      min_d     = 4'd0;
      tmin_d    = 4'd0;
      changed_d = nonzero_q;
    end else begin
      case (state_q)
        IDLE: begin
          if (press_min || press_sec) begin
            step_act = press_min ? ACT_MIN : ACT_SEC;
            act_d    = step_act;
            do_step  = 1'b1;
            cnt_d    = '0;
            state_d  = DELAY;
          end
        end
        DELAY, REPEAT: begin
          // Releasing the active button wins over a step due on the same tick.
          if (!act_btn) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (tick) begin
            if (cnt_inc == ((state_q == DELAY) ? DELAY_LAST : RATE_LAST)) begin
              do_step = 1'b1;
              cnt_d   = '0;
              state_d = REPEAT;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    if (do_step) begin
      if (step_act == ACT_MIN) begin
        if (!min_sat) begin
          min_d     = m_min;
          tmin_d    = m_tmin;
          changed_d = 1'b1;
        end
      end else if (!sec_sat) begin
        sec_d     = s_sec;
        tsec_d    = s_tsec;
        min_d     = s_min;
        tmin_d    = s_tmin;
        changed_d = 1'b1;
      end
    end

    nonzero_d = |{sec_d, tsec_d, min_d, tmin_d};
  end

  // History registers follow the buttons even while locked, so a held button never
  // looks like a fresh press when lock drops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      act_q      <= ACT_SEC;
      cnt_q      <= '0;
      sec_q      <= 4'd0;
      tsec_q     <= 4'd0;
      min_q      <= 4'd0;
      tmin_q     <= 4'd0;
      nonzero_q  <= 1'b0;
      changed_q  <= 1'b0;
      sec_hist_q <= 1'b0;
      min_hist_q <= 1'b0;
      clr_hist_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      act_q      <= act_d;
      cnt_q      <= cnt_d;
      sec_q      <= sec_d;
      tsec_q     <= tsec_d;
      min_q      <= min_d;
      tmin_q     <= tmin_d;
      nonzero_q  <= nonzero_d;
      changed_q  <= changed_d;
      sec_hist_q <= btn_sec;
      min_hist_q <= btn_min;
      clr_hist_q <= btn_clear;
    end
  end

  assign seconds_prog      = sec_q;
  assign tens_seconds_prog = tsec_q;
  assign minutes_prog      = min_q;
  assign tens_minutes_prog = tmin_q;
  assign prog_nonzero      = nonzero_q;
  assign changed           = changed_q;

endmodule

// File: tb/tb_cook_time_entry.sv
// Directed bench for cook_time_entry: carry chain, saturation, auto-repeat,
// priority, lock and asynchronous reset, with hand-computed BCD expectations.
module tb_cook_time_entry;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick, lock, btn_sec, btn_min, btn_clear;
  logic [3:0] seconds_prog, tens_seconds_prog, minutes_prog, tens_minutes_prog;
  logic       prog_nonzero, changed;
  logic [15:0] prog;

  int checks = 0;
  int errors = 0;
  int chg_cnt = 0;

  cook_time_entry #(.REPEAT_DELAY(5), .REPEAT_RATE(2)) dut (
    .clk               (clk),
    .reset             (reset),
    .tick              (tick),
    .lock              (lock),
    .btn_sec           (btn_sec),
    .btn_min           (btn_min),
    .btn_clear         (btn_clear),
    .seconds_prog      (seconds_prog),
    .tens_seconds_prog (tens_seconds_prog),
    .minutes_prog      (minutes_prog),
    .tens_minutes_prog (tens_minutes_prog),
    .prog_nonzero      (prog_nonzero),
    .changed           (changed)
  );

  assign prog = {tens_minutes_prog, minutes_prog, tens_seconds_prog, seconds_prog};

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
    if (changed === 1'b1) chg_cnt++;
  endtask

  task automatic press_sec();
    btn_sec = 1'b1; cycle(); btn_sec = 1'b0; cycle();
  endtask

  task automatic press_min();
    btn_min = 1'b1; cycle(); btn_min = 1'b0; cycle();
  endtask

  task automatic press_clear();
    btn_clear = 1'b1; cycle(); btn_clear = 1'b0; cycle();
  endtask

  task automatic load_time(input int m, input int s);
    press_clear();
    repeat (m) press_min();
    repeat (s) press_sec();
  endtask

  task automatic test_reset();
    reset = 1'b0; tick = 1'b0; lock = 1'b0;
    btn_sec = 1'b0; btn_min = 1'b0; btn_clear = 1'b0;
    #2;
    checks++;
    if (prog !== 16'h0000) begin errors++; $display("[TB] FAIL reset_digits: got %h expected 0000", prog); end
    checks++;
    if (prog_nonzero !== 1'b0 || changed !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_flags: got nz=%b chg=%b expected 0 0", prog_nonzero, changed);
    end
    #21 reset = 1'b1;
    cycle();
    checks++;
    if (prog !== 16'h0000 || changed !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_idle: got %h chg=%b expected 0000 0", prog, changed);
    end
  endtask

  task automatic test_carry();
    chg_cnt = 0;
    btn_sec = 1'b1; cycle();
    checks++;
    if (prog !== 16'h0001 || changed !== 1'b1 || prog_nonzero !== 1'b1) begin
      errors++; $display("[TB] FAIL first_press: got %h chg=%b nz=%b expected 0001 1 1", prog, changed, prog_nonzero);
    end
    btn_sec = 1'b0; cycle();
    checks++;
    if (changed !== 1'b0) begin errors++; $display("[TB] FAIL changed_one_cycle: got %b expected 0", changed); end
    repeat (8) press_sec();
    checks++;
    if (prog !== 16'h0009) begin errors++; $display("[TB] FAIL carry_09: got %h expected 0009", prog); end
    press_sec();
    checks++;
    if (prog !== 16'h0010) begin errors++; $display("[TB] FAIL carry_10: got %h expected 0010", prog); end
    repeat (49) press_sec();
    checks++;
    if (prog !== 16'h0059) begin errors++; $display("[TB] FAIL carry_59: got %h expected 0059", prog); end
    press_sec();
    checks++;
    if (prog !== 16'h0100) begin errors++; $display("[TB] FAIL carry_100: got %h expected 0100", prog); end
    checks++;
    if (chg_cnt !== 60) begin errors++; $display("[TB] FAIL carry_pulses: got %0d expected 60", chg_cnt); end
  endtask

  task automatic test_clear();
    btn_clear = 1'b1; cycle();
    checks++;
    if (prog !== 16'h0000 || changed !== 1'b1 || prog_nonzero !== 1'b0) begin
      errors++; $display("[TB] FAIL clear: got %h chg=%b nz=%b expected 0000 1 0", prog, changed, prog_nonzero);
    end
    btn_clear = 1'b0; cycle();
    btn_clear = 1'b1; cycle();
    checks++;
    if (changed !== 1'b0) begin errors++; $display("[TB] FAIL clear_at_zero: got chg=%b expected 0", changed); end
    btn_clear = 1'b0; cycle();
  endtask

  task automatic test_minute_carry();
    load_time(9, 59);
    press_sec();
    checks++;
    if (prog !== 16'h1000) begin errors++; $display("[TB] FAIL full_carry: got %h expected 1000", prog); end
    press_min();
    checks++;
    if (prog !== 16'h1100) begin errors++; $display("[TB] FAIL minute_step: got %h expected 1100", prog); end
  endtask

  task automatic test_saturation();
    load_time(99, 58);
    chg_cnt = 0;
    repeat (3) press_sec();
    checks++;
    if (prog !== 16'h9959) begin errors++; $display("[TB] FAIL sat_sec_value: got %h expected 9959", prog); end
    checks++;
    if (chg_cnt !== 1) begin errors++; $display("[TB] FAIL sat_sec_pulses: got %0d expected 1", chg_cnt); end
    load_time(99, 30);
    chg_cnt = 0;
    press_min();
    checks++;
    if (prog !== 16'h9930 || chg_cnt !== 0) begin
      errors++; $display("[TB] FAIL sat_min: got %h pulses=%0d expected 9930 0", prog, chg_cnt);
    end
  endtask

  task automatic test_autorepeat();
    logic exp_chg;
    press_clear();
    tick = 1'b1;
    btn_min = 1'b1;
    for (int k = 0; k < 12; k++) begin
      cycle();
      exp_chg = (k == 0) || (k == 5) || (k == 7) || (k == 9) || (k == 11);
      checks++;
      if (changed !== exp_chg) begin
        errors++; $display("[TB] FAIL repeat_cycle%0d: got chg=%b expected %b", k, changed, exp_chg);
      end
    end
    btn_min = 1'b0;
    chg_cnt = 0;
    repeat (6) cycle();
    checks++;
    if (prog !== 16'h0500 || chg_cnt !== 0) begin
      errors++; $display("[TB] FAIL repeat_release: got %h pulses=%0d expected 0500 0", prog, chg_cnt);
    end
    tick = 1'b0;
  endtask

  task automatic test_priority();
    press_clear();
    btn_sec = 1'b1; btn_min = 1'b1; cycle();
    checks++;
    if (prog !== 16'h0100 || changed !== 1'b1) begin
      errors++; $display("[TB] FAIL both_press: got %h chg=%b expected 0100 1", prog, changed);
    end
    cycle();
    btn_min = 1'b0; cycle();
    cycle();
    checks++;
    if (prog !== 16'h0100) begin errors++; $display("[TB] FAIL held_sec_no_step: got %h expected 0100", prog); end
    btn_sec = 1'b0; cycle();
    btn_clear = 1'b1; btn_sec = 1'b1; cycle();
    checks++;
    if (prog !== 16'h0000 || changed !== 1'b1) begin
      errors++; $display("[TB] FAIL clear_over_step: got %h chg=%b expected 0000 1", prog, changed);
    end
    btn_clear = 1'b0; btn_sec = 1'b0; cycle();
    btn_sec = 1'b1; cycle();
    btn_min = 1'b1; cycle();
    checks++;
    if (prog !== 16'h0001 || changed !== 1'b0) begin
      errors++; $display("[TB] FAIL other_ignored: got %h chg=%b expected 0001 0", prog, changed);
    end
    btn_min = 1'b0; cycle();
    btn_sec = 1'b0; cycle();
    press_min();
    checks++;
    if (prog !== 16'h0101) begin errors++; $display("[TB] FAIL idle_press: got %h expected 0101", prog); end
  endtask

  task automatic test_lock();
    lock = 1'b1;
    chg_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      btn_sec   = k[0];
      btn_min   = k[1];
      btn_clear = k[2];
      cycle();
    end
    btn_min = 1'b0; btn_clear = 1'b0; btn_sec = 1'b1;
    cycle();
    checks++;
    if (prog !== 16'h0101 || chg_cnt !== 0) begin
      errors++; $display("[TB] FAIL locked: got %h pulses=%0d expected 0101 0", prog, chg_cnt);
    end
    lock = 1'b0;
    cycle(); cycle();
    checks++;
    if (prog !== 16'h0101 || chg_cnt !== 0) begin
      errors++; $display("[TB] FAIL unlock_held: got %h pulses=%0d expected 0101 0", prog, chg_cnt);
    end
    btn_sec = 1'b0; cycle();
  endtask

  task automatic test_async_reset();
    press_clear();
    tick = 1'b1;
    btn_sec = 1'b1;
    repeat (7) cycle();
    checks++;
    if (prog !== 16'h0002) begin errors++; $display("[TB] FAIL pre_reset: got %h expected 0002", prog); end
    #3 reset = 1'b0;
    #1;
    checks++;
    if (prog !== 16'h0000 || prog_nonzero !== 1'b0 || changed !== 1'b0) begin
      errors++; $display("[TB] FAIL async_reset: got %h nz=%b chg=%b expected 0000 0 0", prog, prog_nonzero, changed);
    end
    btn_sec = 1'b0;
    #2 reset = 1'b1;
    chg_cnt = 0;
    repeat (8) cycle();
    checks++;
    if (prog !== 16'h0000 || chg_cnt !== 0) begin
      errors++; $display("[TB] FAIL post_reset_idle: got %h pulses=%0d expected 0000 0", prog, chg_cnt);
    end
    tick = 1'b0;
    press_min();
    checks++;
    if (prog !== 16'h0100) begin errors++; $display("[TB] FAIL post_reset_press: got %h expected 0100", prog); end
  endtask

  initial begin
    test_reset();
    test_carry();
    test_clear();
    test_minute_carry();
    test_saturation();
    test_autorepeat();
    test_priority();
    test_lock();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] time limit");
  end

endmodule
